// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file write-port arbiter.
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 64;
  localparam int REGFILE_ADDR_W   = 5;
  localparam int REGFILE_NUM_REGS = 32;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } regwr_state_e;

  typedef struct packed {
    logic                      en;
    logic [REGFILE_ADDR_W-1:0] rd;
    logic [REGFILE_DATA_W-1:0] data;
  } regwr_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-input round-robin grant logic; the priority pointer only moves after a contested grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic prio;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        prio <= 1'b0;
    else if (en && (valid == 2'b11))   prio <= ~prio;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback with registered outputs.
// Define REGFILE_CLEAR_EN to compile in the x1..x(NUM_REGS-1) clear sequencer.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_REGS = REGFILE_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_rd,
  output logic [DATA_W-1:0] wr_data
);

  logic              arb_en;
  logic              clear_issue;
  logic [ADDR_W-1:0] clr_idx;
  logic [1:0]        grant;

`ifdef REGFILE_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  regwr_state_e      state, state_nxt;
  logic [ADDR_W-1:0] clr_idx_nxt;
  logic              busy_q;
  logic              start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ARB;
      clr_idx <= ADDR_W'(1);
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      // busy covers the walk plus the cycle the last zero write is on the port
      busy_q  <= (state == CLEAR) || (state_nxt == CLEAR);
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    start       = 1'b0;
    arb_en      = 1'b0;
    clear_issue = 1'b0;
    case (state)
      ARB: begin
        start       = clear_start && !busy_q;
        arb_en      = reset && !start;
        clear_issue = start;
      end
      CLEAR: clear_issue = 1'b1;
      default: state_nxt = ARB;
    endcase
    if (clear_issue) begin
      if (clr_idx == LAST_IDX) begin
        state_nxt   = ARB;
        clr_idx_nxt = ADDR_W'(1);
      end else begin
        state_nxt   = CLEAR;
        clr_idx_nxt = clr_idx + ADDR_W'(1);
      end
    end
  end

  assign clear_busy = busy_q;
`else
  logic unused_clear;

  assign arb_en       = reset;
  assign clear_issue  = 1'b0;
  assign clr_idx      = '0;
  assign clear_busy   = 1'b0;
  assign unused_clear = clear_start ^ (NUM_REGS == 0);
`endif

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // stage p0: select the write for the port; x0 is accepted but never written
  logic              wr_vld_p0;
  logic [ADDR_W-1:0] wr_rd_p0;
  logic [DATA_W-1:0] wr_data_p0;
  logic              wr_vld_p1;
  logic [ADDR_W-1:0] wr_rd_p1;
  logic [DATA_W-1:0] wr_data_p1;

  always_comb begin
    wr_vld_p0  = 1'b0;
    wr_rd_p0   = wr_rd_p1;
    wr_data_p0 = wr_data_p1;
    if (clear_issue) begin
      wr_vld_p0  = 1'b1;
      wr_rd_p0   = clr_idx;
      wr_data_p0 = '0;
    end else if (grant[0]) begin
      wr_vld_p0  = (req0_rd != '0);
      wr_rd_p0   = req0_rd;
      wr_data_p0 = req0_data;
    end else if (grant[1]) begin
      wr_vld_p0  = (req1_rd != '0);
      wr_rd_p0   = req1_rd;
      wr_data_p0 = req1_data;
    end
  end

  // stage p1: registered write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_vld_p1  <= 1'b0;
      wr_rd_p1   <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1  <= wr_vld_p0;
      wr_rd_p1   <= wr_rd_p0;
      wr_data_p1 <= wr_data_p0;
    end
  end

  assign wr_en   = wr_vld_p1;
  assign wr_rd   = wr_rd_p1;
  assign wr_data = wr_data_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int DW = REGFILE_DATA_W;
  localparam int AW = REGFILE_ADDR_W;
  localparam int NR = REGFILE_NUM_REGS;
`ifdef REGFILE_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_rd, req1_rd;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          clear_start, clear_busy;
  logic          wr_en;
  logic [AW-1:0] wr_rd;
  logic [DW-1:0] wr_data;

  regfile_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_rd     (req0_rd),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_rd     (req1_rd),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .wr_en       (wr_en),
    .wr_rd       (wr_rd),
    .wr_data     (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  int     turn;
  int     busy_cycles;
  int     walk[$];
  regwr_t m_out;
  bit     g0, g1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    turn        = 0;
    busy_cycles = 0;
    walk.delete();
    m_out       = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_wr_en"},   64'(wr_en),      64'd0);
    check_val({tag, "_wr_rd"},   64'(wr_rd),      64'd0);
    check_val({tag, "_wr_data"}, 64'(wr_data),    64'd0);
    check_val({tag, "_busy"},    64'(clear_busy), 64'd0);
    check_val({tag, "_ready0"},  64'(req0_ready), 64'd0);
    check_val({tag, "_ready1"},  64'(req1_ready), 64'd0);
  endtask

  // One clock: check DUT against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    bit st;
    @(negedge clk);
    st = CLEAR_EN && clear_start && (busy_cycles == 0) && (walk.size() == 0);
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset && (walk.size() == 0) && !st) begin
      if (req0_valid && req1_valid) begin
        if (turn == 0) g0 = 1'b1;
        else           g1 = 1'b1;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    check_val("ready0", 64'(req0_ready), 64'(g0));
    check_val("ready1", 64'(req1_ready), 64'(g1));
    check_val("busy",   64'(clear_busy), 64'(busy_cycles > 0));
    check_val("wr_en",  64'(wr_en),      64'(m_out.en));
    if (m_out.en) begin
      check_val("wr_rd",   64'(wr_rd),   64'(m_out.rd));
      check_val("wr_data", 64'(wr_data), 64'(m_out.data));
    end
    @(posedge clk);
    if (busy_cycles > 0) busy_cycles--;
    if (walk.size() > 0) begin
      m_out.en   = 1'b1;
      m_out.rd   = AW'(walk.pop_front());
      m_out.data = '0;
    end else if (st) begin
      m_out.en   = 1'b1;
      m_out.rd   = AW'(1);
      m_out.data = '0;
      for (int i = 2; i < NR; i++) walk.push_back(i);
      busy_cycles = NR - 1;
    end else if (g0) begin
      m_out.en   = (req0_rd != 0);
      m_out.rd   = req0_rd;
      m_out.data = req0_data;
      if (req1_valid) turn = 1;
    end else if (g1) begin
      m_out.en   = (req1_rd != 0);
      m_out.rd   = req1_rd;
      m_out.data = req1_data;
      if (req0_valid) turn = 0;
    end else begin
      m_out.en = 1'b0;
    end
    #1;
  endtask

  task automatic drive_rand();
    if (!(req0_valid && !g0)) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_rd    = AW'($urandom_range(0, NR - 1));
      req0_data  = {$urandom, $urandom};
    end
    if (!(req1_valid && !g1)) begin
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_rd    = ($urandom_range(0, 3) == 0) ? req0_rd : AW'($urandom_range(0, NR - 1));
      req1_data  = {$urandom, $urandom};
    end
    clear_start = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    req0_valid  = 1'b1;
    req1_valid  = 1'b1;
    req0_rd     = '1;
    req1_rd     = '1;
    req0_data   = '1;
    req1_data   = '1;
    clear_start = 1'b1;
    model_reset();
    g0 = 1'b0;
    g1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");

    clear_start = 1'b0;
    req1_valid  = 1'b0;
    req0_rd     = AW'(5);
    req0_data   = 64'hDEAD;
    reset       = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    step();

    req0_valid = 1'b1; req0_rd = AW'(3); req0_data = 64'hAAAA_0000_0000_000A;
    req1_valid = 1'b1; req1_rd = AW'(4); req1_data = 64'hBBBB_0000_0000_000B;
    repeat (4) step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    req1_valid = 1'b1; req1_rd = '0; req1_data = 64'h1;
    step();
    req1_valid = 1'b0;
    step();

    req0_valid = 1'b1; req0_rd = AW'(7); req0_data = 64'h77;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (33) step();
    req0_valid = 1'b0;
    step();

    clear_start = 1'b1;
    req1_valid = 1'b1; req1_rd = AW'(9); req1_data = 64'h99;
    step();
    clear_start = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    model_reset();
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    step();

    repeat (600) begin
      drive_rand();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
